// File: rtl/hsv_pkg.sv
// hsv_pkg: shared types, constants and hue-base lookup for the rgb_to_hsv pipeline
package hsv_pkg;
  typedef struct packed {
    logic [8:0] h;
    logic [7:0] s;
    logic [7:0] v;
  } hsv_t;
  typedef enum logic [1:0] {SEC_R, SEC_G, SEC_B} sector_t;
  localparam int HUE_MAX = 359;
  localparam int HUE_WRAP = 360;
  localparam int PIPE_LAT = 10;
  function automatic logic [9:0] hue_base(sector_t sec);
    return sec == SEC_R ? 10'd0 : sec == SEC_G ? 10'd120 : 10'd240;
  endfunction
endpackage

// File: rtl/hsv_div_pipe.sv
// hsv_div_pipe: 8-stage two-lane restoring divider (16b / 8b -> 8b), one quotient bit per stage,
// with stall enable and a valid/sideband pass-through aligned to the quotients.
module hsv_div_pipe #(
  parameter int SW = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en_i,
  input  logic          valid_i,
  input  logic [15:0]   num_a_i,
  input  logic [7:0]    den_a_i,
  input  logic [15:0]   num_b_i,
  input  logic [7:0]    den_b_i,
  input  logic [SW-1:0] side_i,
  output logic          valid_o,
  output logic [7:0]    q_a_o,
  output logic [7:0]    q_b_o,
  output logic [SW-1:0] side_o
);
  typedef struct packed {
    logic          v;
    logic [15:0]   ra;
    logic [15:0]   rb;
    logic [7:0]    da;
    logic [7:0]    db;
    logic [7:0]    qa;
    logic [7:0]    qb;
    logic [SW-1:0] sd;
  } stg_t;
  stg_t in_s;
  stg_t st_d [8];
  stg_t st_q [8];
  // quotients never exceed 255, so the remainder always fits below den << 8
  function automatic stg_t step(stg_t s, int sh);
    stg_t r;
    logic [15:0] ta, tb;
    logic ga, gb;
    ta = 16'(s.da) << sh;
    tb = 16'(s.db) << sh;
    ga = s.ra >= ta;
    gb = s.rb >= tb;
    r = s;
    r.ra = ga ? s.ra - ta : s.ra;
    r.rb = gb ? s.rb - tb : s.rb;
    r.qa = {s.qa[6:0], ga};
    r.qb = {s.qb[6:0], gb};
    return r;
  endfunction
  always_comb begin
    in_s = '{v: valid_i, ra: num_a_i, rb: num_b_i, da: den_a_i, db: den_b_i, qa: 8'd0, qb: 8'd0, sd: side_i};
    st_d[0] = step(in_s, 7);
    for (int k = 1; k < 8; k++) st_d[k] = step(st_q[k-1], 7 - k);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) for (int k = 0; k < 8; k++) st_q[k] <= '0;
    else if (en_i) st_q <= st_d;
  assign valid_o = st_q[7].v;
  assign q_a_o = st_q[7].qa;
  assign q_b_o = st_q[7].qb;
  assign side_o = st_q[7].sd;
endmodule

// File: rtl/rgb_to_hsv.sv
// rgb_to_hsv: 10-stage stallable RGB-to-HSV pipeline (max/min stage, 8-stage divider, assembly stage).
// Defining HSV_PACKET_EN adds in_sop/in_eop/out_sop/out_eop carried alongside each pixel.
module rgb_to_hsv import hsv_pkg::*; (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_r,
  input  logic [7:0] in_g,
  input  logic [7:0] in_b,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [8:0] out_h,
  output logic [7:0] out_s,
  output logic [7:0] out_v,
  output logic       out_valid,
`ifdef HSV_PACKET_EN
  input  logic       in_sop,
  input  logic       in_eop,
  output logic       out_sop,
  output logic       out_eop,
`endif
  input  logic       out_ready
);
`ifdef HSV_PACKET_EN
  localparam int PW = 2;
`else
  localparam int PW = 0;
`endif
  localparam int SW = 11 + PW;
  logic en;
  logic s1_v_q, s1_neg_q;
  logic [7:0] s1_max_q, s1_min_q, s1_delta_q, s1_mag_q;
  sector_t s1_sec_q, sec_d, sec_o;
  logic [7:0] max_d, min_d, dif_a, dif_b;
  logic zero, dv;
  logic [SW-1:0] side_in, side_out;
  logic [7:0] q_s, q_h;
  logic [9:0] hs;
  hsv_t res_d, res_q;
  logic ov_q;
  assign en = out_ready | ~ov_q;
  assign in_ready = en;
  always_comb begin
    sec_d = (in_r >= in_g && in_r >= in_b) ? SEC_R : (in_g >= in_b) ? SEC_G : SEC_B;
    max_d = sec_d == SEC_R ? in_r : sec_d == SEC_G ? in_g : in_b;
    min_d = (in_r <= in_g && in_r <= in_b) ? in_r : (in_g <= in_b) ? in_g : in_b;
    dif_a = sec_d == SEC_R ? in_g : sec_d == SEC_G ? in_b : in_r;
    dif_b = sec_d == SEC_R ? in_b : sec_d == SEC_G ? in_r : in_g;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1_v_q <= 1'b0;
      s1_max_q <= '0;
      s1_min_q <= '0;
      s1_delta_q <= '0;
      s1_sec_q <= SEC_R;
      s1_neg_q <= 1'b0;
      s1_mag_q <= '0;
    end else if (en) begin
      s1_v_q <= in_valid;
      s1_max_q <= max_d;
      s1_min_q <= min_d;
      s1_delta_q <= max_d - min_d;
      s1_sec_q <= sec_d;
      s1_neg_q <= dif_a < dif_b;
      s1_mag_q <= dif_a < dif_b ? dif_b - dif_a : dif_a - dif_b;
    end
  // grey and black pixels divide 0 by 1 so the divider never sees a zero divisor
  assign zero = s1_max_q == s1_min_q;
`ifdef HSV_PACKET_EN
  logic [1:0] s1_pkt_q, pkt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1_pkt_q <= '0;
      pkt_q <= '0;
    end else if (en) begin
      s1_pkt_q <= {in_sop, in_eop};
      pkt_q <= side_out[12:11];
    end
  assign side_in = {s1_pkt_q, s1_sec_q, s1_neg_q, s1_max_q};
  assign out_sop = pkt_q[1];
  assign out_eop = pkt_q[0];
`else
  assign side_in = {s1_sec_q, s1_neg_q, s1_max_q};
`endif
  hsv_div_pipe #(.SW(SW)) u_div (
    .clk,
    .reset,
    .en_i(en),
    .valid_i(s1_v_q),
    .num_a_i(zero ? 16'd0 : 16'(s1_delta_q) * 16'd255),
    .den_a_i(zero ? 8'd1 : s1_max_q),
    .num_b_i(zero ? 16'd0 : 16'(s1_mag_q) * 16'd60),
    .den_b_i(zero ? 8'd1 : s1_delta_q),
    .side_i(side_in),
    .valid_o(dv),
    .q_a_o(q_s),
    .q_b_o(q_h),
    .side_o(side_out)
  );
  assign sec_o = sector_t'(side_out[10:9]);
  always_comb begin
    hs = side_out[8] ? hue_base(sec_o) + 10'(HUE_WRAP) - 10'(q_h) : hue_base(sec_o) + 10'(q_h);
    res_d = '{h: hs >= 10'(HUE_WRAP) ? 9'(hs - 10'(HUE_WRAP)) : hs[8:0], s: q_s, v: side_out[7:0]};
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      res_q <= '0;
      ov_q <= 1'b0;
    end else if (en) begin
      res_q <= res_d;
      ov_q <= dv;
    end
  assign out_h = res_q.h;
  assign out_s = res_q.s;
  assign out_v = res_q.v;
  assign out_valid = ov_q;
endmodule

// File: tb/tb_rgb_to_hsv.sv
// tb_rgb_to_hsv: directed vectors against an arithmetic HSV model with an in-order scoreboard
module tb_rgb_to_hsv;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] in_r = '0, in_g = '0, in_b = '0;
  logic in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid;
  logic [8:0] out_h;
  logic [7:0] out_s, out_v;
`ifdef HSV_PACKET_EN
  logic in_sop = 1'b0, in_eop = 1'b0, out_sop, out_eop;
`endif
  int total = 0, bad = 0, rx = 0, sop_cnt = 0, eop_cnt = 0;
  typedef struct {int h; int s; int v; int sop; int eop;} exp_t;
  exp_t exp_q[$];
  logic stall_prev = 1'b0;
  int held = 0;

  always #5 clk = ~clk;

  rgb_to_hsv dut (
    .clk(clk), .reset(reset), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .in_valid(in_valid), .in_ready(in_ready), .out_h(out_h), .out_s(out_s), .out_v(out_v),
    .out_valid(out_valid),
`ifdef HSV_PACKET_EN
    .in_sop(in_sop), .in_eop(in_eop), .out_sop(out_sop), .out_eop(out_eop),
`endif
    .out_ready(out_ready)
  );

  function automatic exp_t model(int r, int g, int b, int sop, int eop);
    exp_t e;
    int mx, mn, d, diff, base, q, h;
    mx = r > g ? (r > b ? r : b) : (g > b ? g : b);
    mn = r < g ? (r < b ? r : b) : (g < b ? g : b);
    d = mx - mn;
    e.v = mx; e.h = 0; e.s = 0; e.sop = sop; e.eop = eop;
    if (d != 0) begin
      e.s = 255 * d / mx;
      if (r == mx) begin base = 0; diff = g - b; end
      else if (g == mx) begin base = 120; diff = b - r; end
      else begin base = 240; diff = r - g; end
      q = 60 * (diff < 0 ? -diff : diff) / d;
      h = diff < 0 ? base - q : base + q;
      if (h < 0) h += 360;
      if (h == 360) h = 0;
      e.h = h;
    end
    return e;
  endfunction

  task automatic check(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    int sp, ep;
    if (reset) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      check("in_ready_rule", int'(in_ready), int'(!(out_valid && !out_ready)));
      if (stall_prev) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_data", int'({out_h, out_s, out_v}), held);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_output: got h=%0d s=%0d v=%0d expected none", out_h, out_s, out_v);
        end else begin
          e = exp_q.pop_front();
          check("out_h", int'(out_h), e.h);
          check("out_s", int'(out_s), e.s);
          check("out_v", int'(out_v), e.v);
`ifdef HSV_PACKET_EN
          check("out_sop", int'(out_sop), e.sop);
          check("out_eop", int'(out_eop), e.eop);
          sop_cnt += int'(out_sop);
          eop_cnt += int'(out_eop);
`endif
          rx++;
        end
      end
      sp = 0; ep = 0;
`ifdef HSV_PACKET_EN
      sp = int'(in_sop); ep = int'(in_eop);
`endif
      if (in_valid && in_ready) exp_q.push_back(model(int'(in_r), int'(in_g), int'(in_b), sp, ep));
      stall_prev = out_valid && !out_ready;
      held = int'({out_h, out_s, out_v});
    end
  end

  task automatic single(input string nm, input int r, input int g, input int b,
                        input int eh, input int es, input int ev);
    int n;
    in_r = 8'(r); in_g = 8'(g); in_b = 8'(b); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 30) begin @(posedge clk); #1; n++; end
    check({nm, "_latency"}, n, 10);
    check({nm, "_h"}, int'(out_h), eh);
    check({nm, "_s"}, int'(out_s), es);
    check({nm, "_v"}, int'(out_v), ev);
    @(posedge clk); #1;
  endtask

  initial begin
    int i, cyc, lowcnt, rx0, n, cnt;
    logic acc;
    logic [7:0] pr [20], pg [20], pb [20];
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_hsv", int'({out_h, out_s, out_v}), 0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;

    check("pin_model_h", model(10, 200, 50, 0, 0).h, 132);
    check("pin_model_s", model(200, 50, 51, 0, 0).s, 191);
    check("pin_model_wrap", model(255, 0, 128, 0, 0).h, 330);

    single("red", 255, 0, 0, 0, 255, 255);
    single("green_mix", 10, 200, 50, 132, 242, 200);
    single("wrap", 255, 0, 128, 330, 255, 255);
    single("grey", 100, 100, 100, 0, 0, 100);
    single("black", 0, 0, 0, 0, 0, 0);
    single("tie_rg", 255, 255, 0, 60, 255, 255);
    single("tie_gb", 0, 255, 255, 180, 255, 255);
    single("blue_neg", 0, 128, 255, 210, 255, 255);
    single("neg_zero_q", 200, 50, 51, 0, 191, 200);
    single("near_60", 255, 254, 0, 59, 255, 255);

    for (int k = 0; k < 20; k++) begin
      pr[k] = 8'((k * 37 + 11) % 256);
      pg[k] = 8'((k * 91 + 3) % 256);
      pb[k] = 8'((k * 53 + 200) % 256);
    end
    pr[3] = 8'd7; pg[3] = 8'd7; pb[3] = 8'd7;
    pr[7] = 8'd0; pg[7] = 8'd0; pb[7] = 8'd0;
    rx0 = rx; i = 0; cyc = 0; lowcnt = 0;
    while (i < 20 && cyc < 200) begin
      out_ready = !(cyc >= 12 && cyc < 17);
      in_r = pr[i]; in_g = pg[i]; in_b = pb[i]; in_valid = 1'b1;
      #1;
      acc = in_ready;
      if (!acc) lowcnt++;
      @(posedge clk); #1;
      if (acc) i++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stream_accepted", i, 20);
    check("stall_in_ready_low", lowcnt, 5);
    n = 0;
    while (rx - rx0 < 20 && n < 100) begin @(posedge clk); #1; n++; end
    check("stream_received", rx - rx0, 20);
    repeat (2) @(posedge clk); #1;

    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      in_r = 8'(k * 40); in_g = 8'(255 - k * 30); in_b = 8'(k * 7 + 1); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (12) @(posedge clk); #1;
    check("rst_pre_valid", int'(out_valid), 1);
    #2 reset = 1'b1;
    #1;
    check("rst_async_valid", int'(out_valid), 0);
    check("rst_async_hsv", int'({out_h, out_s, out_v}), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rst_release_in_ready", int'(in_ready), 1);
    cnt = 0;
    repeat (20) begin @(posedge clk); #1; cnt += int'(out_valid); end
    check("rst_no_ghosts", cnt, 0);

`ifdef HSV_PACKET_EN
    sop_cnt = 0; eop_cnt = 0; rx0 = rx;
    for (int k = 0; k < 4; k++) begin
      in_r = 8'(50 + k * 60); in_g = 8'(200 - k * 40); in_b = 8'(k * 20);
      in_sop = (k == 0); in_eop = (k == 3); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    n = 0;
    while (rx - rx0 < 4 && n < 50) begin @(posedge clk); #1; n++; end
    check("pkt_received", rx - rx0, 4);
    check("pkt_sop_count", sop_cnt, 1);
    check("pkt_eop_count", eop_cnt, 1);
`endif

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
